l2_bank_ctrl: RTL
=================

# l2_bank_ctrl

Controller in front of one private L2 SRAM bank. It zero-fills the bank after reset or on request, then shares the bank's single port between NB_REQ requesters, such as the FC core data port and the uDMA, using round-robin arbitration. It sits between the SoC interconnect and one 32-bit, single-cycle-read bank instance in the L2 memory wrapper.

## Interface
- NB_REQ, 2: number of requesters (2..4).
- ADDR_WIDTH, 13: bank word-address width.
- INIT_ON_RESET, 1: when 1, zero-fill starts automatically after reset.
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, synchronous, active-high (already decided).
- init_req_i  in  1  one-cycle pulse; starts a zero-fill, honoured only in READY.
- init_busy_o  out  1  high while zero-fill is running.
- req_i  in  NB_REQ  per-requester request.
- gnt_o  out  NB_REQ  per-requester grant; one-hot or zero.
- wen_i  in  NB_REQ  per-requester write enable, active-low (0 = write).
- be_i  in  NB_REQ x 4  byte enables, active-high.
- add_i  in  NB_REQ x ADDR_WIDTH  word address.
- wdata_i  in  NB_REQ x 32  write data.
- r_valid_o  out  NB_REQ  response strobe; issued for reads and writes.
- r_rdata_o  out  32  read data, shared by all requesters.
- mem_csn_o  out  1  bank chip select, active-low.
- mem_wen_o  out  1  bank write enable, active-low.
- mem_be_o  out  4  bank byte enables, active-high; the bank wrapper inverts them.
- mem_add_o  out  ADDR_WIDTH  bank address.
- mem_wdata_o  out  32  bank write data.
- mem_rdata_i  in  32  bank read data, valid the cycle after the access.

## Operation
- FSM states:
  - IDLE: after reset; lasts one cycle.
  - INIT: zero-filling the bank.
  - READY: serving requesters.
- IDLE transitions:
  - to INIT when INIT_ON_RESET = 1;
  - otherwise to READY.
- INIT:
  - Each cycle drives csn = 0, wen = 0, be = 4'hF, wdata = 0, add = init_cnt.
  - init_cnt runs from 0 to 2^ADDR_WIDTH − 1.
  - On the last address, go to READY and clear init_cnt.
  - gnt_o = 0 throughout; init_busy_o = 1.
- READY:
  - Arbitration is combinational: the winner is the first asserted req_i at or after rr_ptr, searching cyclically.
  - The winner gets gnt_o in the same cycle, and its request is forwarded to the bank ports.
  - On a grant, rr_ptr ← winner + 1 mod NB_REQ.
  - With no request: mem_csn_o = 1, rr_ptr unchanged, other mem outputs don't-care.
- READY → INIT on init_req_i:
  - The transition happens the next cycle.
  - Any grant issued in the init_req_i cycle still completes; its r_valid is delivered during the first INIT cycle.
- init_req_i while in IDLE or INIT is ignored.
- Response path:
  - The winner index and a valid flag are registered.
  - r_valid_o[winner] = 1 the following cycle.
  - r_rdata_o = mem_rdata_i, which is meaningful only for reads.

## Timing
- Grant to r_valid latency: 1 cycle. Throughput: 1 access per cycle. No back-pressure on responses.
- Zero-fill duration: 2^ADDR_WIDTH cycles in INIT (8192 at the default), plus 1 IDLE cycle.
- Reset values:
  - state = IDLE, rr_ptr = 0, init_cnt = 0;
  - gnt_o = 0, r_valid_o = 0, init_busy_o = 0, mem_csn_o = 1, mem_wen_o = 1, mem_be_o = 0, mem_add_o = 0, mem_wdata_o = 0, r_rdata_o = 0;
  - rdata is passthrough, so r_rdata_o is 0 only when the bank outputs 0.
- Reset asserted mid-INIT: abort. Next cycle is IDLE with init_cnt = 0, and the fill restarts from address 0 when INIT_ON_RESET = 1.
- Reset in the cycle after a grant: the pending r_valid is dropped.
- Simultaneous init_req_i and requests in READY: the request is granted this cycle; INIT takes the port next cycle.
- Requester protocol:
  - Request fields must stay stable while req_i is high and not granted.
  - Dropping req_i before grant is allowed.
- init_cnt wraps only on the INIT exit; it is never used in READY.

## Structure
- Package l2_bank_ctrl_pkg holds:
  - the state enum (IDLE, INIT, READY);
  - the response record (valid, winner index);
  - the constant ZERO_WORD.
- Sub-module l2_rr_arbiter: NB_REQ-way round-robin with rr_ptr register, inputs req/advance, outputs one-hot grant and winner index.
- The top level holds the FSM, init counter, bank mux and response register.

## Test plan
- Reset with INIT_ON_RESET = 1 and ADDR_WIDTH = 4:
  - init_busy_o high for 16 cycles; mem writes land at addresses 0..15 with wdata 0, be F;
  - then READY; reading address 7 returns 0x0000_0000.
- Both requesters hold continuous reads at address 3:
  - grants alternate 0,1,0,1;
  - each r_valid arrives exactly 1 cycle after its grant;
  - r_rdata_o matches the bank model.
- Requester 1 writes 0xDEADBEEF with be = 4'b0101 to address 5, then requester 0 reads address 5:
  - the read returns 0x00AD00EF on r_valid_o[0].
- Pulse init_req_i in the same cycle requester 0 is granted a write to address 2:
  - the write completes with r_valid in the first INIT cycle;
  - zero-fill then runs;
  - a later read of address 2 returns 0.
- Assert rst_i at init_cnt = 9:
  - next cycle IDLE with all outputs at reset values;
  - the fill restarts at address 0 and completes the full count.
- Assert init_req_i while init_busy_o = 1:
  - ignored; the fill duration is unchanged, and there is no second fill.

Source files
------------

// File: rtl/l2_bank_ctrl_pkg.sv
// Shared types and constants for the L2 bank controller.
package l2_bank_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_READY
    } state_e;

    // Wide enough for up to 4 requesters.
    localparam int IDX_W = 2;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } resp_t;

endpackage

// File: rtl/l2_rr_arbiter.sv
// NB_REQ-way round-robin arbiter; the winner is the first request at or after ptr.
module l2_rr_arbiter
    import l2_bank_ctrl_pkg::*;
#(
    parameter int NB_REQ = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NB_REQ-1:0] req_i,
    input  logic              advance_i,
    output logic [NB_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              valid_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int off = 0; off < NB_REQ; off++) begin
            for (int j = 0; j < NB_REQ; j++) begin
                if (!valid_o && req_i[j] && (j == (int'(ptr_q) + off) % NB_REQ)) begin
                    valid_o  = 1'b1;
                    gnt_o[j] = 1'b1;
                    idx_o    = IDX_W'(j);
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && valid_o) begin
            ptr_d = IDX_W'((int'(idx_o) + 1) % NB_REQ);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/l2_bank_ctrl.sv
// L2 bank front-end: zero-fill sequencer plus round-robin sharing of the single bank port.
module l2_bank_ctrl
    import l2_bank_ctrl_pkg::*;
#(
    parameter int NB_REQ        = 2,
    parameter int ADDR_WIDTH    = 13,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               init_req_i,
    output logic                               init_busy_o,
    input  logic [NB_REQ-1:0]                  req_i,
    output logic [NB_REQ-1:0]                  gnt_o,
    input  logic [NB_REQ-1:0]                  wen_i,
    input  logic [NB_REQ-1:0][3:0]             be_i,
    input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]  add_i,
    input  logic [NB_REQ-1:0][31:0]            wdata_i,
    output logic [NB_REQ-1:0]                  r_valid_o,
    output logic [31:0]                        r_rdata_o,
    output logic                               mem_csn_o,
    output logic                               mem_wen_o,
    output logic [3:0]                         mem_be_o,
    output logic [ADDR_WIDTH-1:0]              mem_add_o,
    output logic [31:0]                        mem_wdata_o,
    input  logic [31:0]                        mem_rdata_i
);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
    resp_t                   resp_q, resp_d;

    logic [NB_REQ-1:0]       arb_req;
    logic [NB_REQ-1:0]       arb_gnt;
    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_valid;

    // Requests are only visible to the arbiter in READY, so its pointer freezes elsewhere.
    assign arb_req = (state_q == ST_READY) ? req_i : '0;

    l2_rr_arbiter #(
        .NB_REQ (NB_REQ)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (arb_req),
        .advance_i (state_q == ST_READY),
        .gnt_o     (arb_gnt),
        .idx_o     (arb_idx),
        .valid_o   (arb_valid)
    );

    assign gnt_o     = arb_gnt;
    assign r_rdata_o = mem_rdata_i;

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        resp_d       = '0;
        init_busy_o  = 1'b0;
        mem_csn_o    = 1'b1;
        mem_wen_o    = 1'b1;
        mem_be_o     = 4'h0;
        mem_add_o    = '0;
        mem_wdata_o  = ZERO_WORD;

        case (state_q)
            ST_IDLE: begin
                state_d = (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
            end
            ST_INIT: begin
                init_busy_o = 1'b1;
                mem_csn_o   = 1'b0;
                mem_wen_o   = 1'b0;
                mem_be_o    = 4'hF;
                mem_add_o   = init_cnt_q;
                if (init_cnt_q == '1) begin
                    state_d    = ST_READY;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_READY: begin
                // A grant issued alongside init_req_i still completes; INIT starts next cycle.
                for (int j = 0; j < NB_REQ; j++) begin
                    if (arb_gnt[j]) begin
                        mem_csn_o   = 1'b0;
                        mem_wen_o   = wen_i[j];
                        mem_be_o    = be_i[j];
                        mem_add_o   = add_i[j];
                        mem_wdata_o = wdata_i[j];
                    end
                end
                resp_d.valid = arb_valid;
                resp_d.idx   = arb_idx;
                if (init_req_i) begin
                    state_d = ST_INIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < NB_REQ; i++) begin
            r_valid_o[i] = resp_q.valid && (resp_q.idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            init_cnt_q <= '0;
            resp_q     <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            resp_q     <= resp_d;
        end
    end

endmodule
